// File: rtl/actuator_pkg.sv
// Shared definitions for the actuator output stage: motor command encoding,
// motor FSM state set and the straight-ahead steering code.
package actuator_pkg;

    localparam logic [1:0] CMD_COAST = 2'b00;
    localparam logic [1:0] CMD_FWD   = 2'b01;
    localparam logic [1:0] CMD_REV   = 2'b10;
    localparam logic [1:0] CMD_BRAKE = 2'b11;

    localparam logic [2:0] STEER_CENTER = 3'd3;

    typedef enum logic [2:0] {
        ST_COAST,
        ST_FWD,
        ST_REV,
        ST_BRAKE,
        ST_DEAD
    } motor_state_t;

    function automatic motor_state_t cmd_to_state(input logic [1:0] cmd);
        motor_state_t st;
        st = ST_COAST;
        case (cmd)
            CMD_COAST: st = ST_COAST;
            CMD_FWD:   st = ST_FWD;
            CMD_REV:   st = ST_REV;
            CMD_BRAKE: st = ST_BRAKE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo pulse generator: free-running frame counter, frame-start latch of the
// steering code and registered width comparator.
module servo_pwm_gen
    import actuator_pkg::*;
#(
    parameter int SERVO_PERIOD = 20000,
    parameter int SERVO_CENTER = 1500,
    parameter int SERVO_STEP   = 150
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] front_wheel,
    output logic       servo_pwm
);

    localparam int SCW = $clog2(SERVO_PERIOD);

    logic [SCW-1:0] scnt;
    logic [SCW-1:0] width_q;
    logic [SCW-1:0] width_new;
    logic [SCW-1:0] width_eff;
    logic           frame_start;

    // Code 7 is folded onto straight ahead; offset math is signed.
    function automatic logic [SCW-1:0] steer_width(input logic [2:0] code);
        logic signed [31:0] delta;
        logic signed [31:0] w;
        if (code == 3'd7) begin
            delta = 32'sd0;
        end else begin
            delta = $signed({29'd0, code}) - $signed({29'd0, STEER_CENTER});
        end
        w = SERVO_CENTER + delta * SERVO_STEP;
        return SCW'(w);
    endfunction

    assign frame_start = (scnt == '0);
    assign width_new   = steer_width(front_wheel);
    // The new width must already apply on the frame-start compare itself.
    assign width_eff   = frame_start ? width_new : width_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scnt      <= '0;
            width_q   <= '0;
            servo_pwm <= 1'b0;
        end else begin
            if (scnt == SCW'(SERVO_PERIOD - 1)) begin
                scnt <= '0;
            end else begin
                scnt <= scnt + 1'b1;
            end
            if (frame_start) begin
                width_q <= width_new;
            end
            servo_pwm <= (scnt < width_eff);
        end
    end

endmodule

// File: rtl/actuator_drive.sv
// Actuator output stage: servo PWM plus H-bridge drive with dead time on polarity
// change. Optional motor soft-start ramp enabled by ACTUATOR_SOFT_START_EN.
module actuator_drive
    import actuator_pkg::*;
#(
    parameter int SERVO_PERIOD = 20000,
    parameter int SERVO_CENTER = 1500,
    parameter int SERVO_STEP   = 150,
    parameter int MOTOR_PERIOD = 100,
    parameter int MOTOR_DUTY   = 60,
    parameter int DEAD_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] front_wheel,
    input  logic [1:0] motor,
    output logic       servo_pwm,
    output logic       motor_a,
    output logic       motor_b,
    output logic       reversing
);

    localparam int MCW = $clog2(MOTOR_PERIOD);
    localparam int DW  = MCW + 1;
    localparam int DTW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DTW-1:0] DEAD_LOAD = DTW'(DEAD_CYCLES - 1);

    if ((SERVO_CENTER < 3 * SERVO_STEP) ||
        (SERVO_CENTER + 3 * SERVO_STEP >= SERVO_PERIOD)) begin : g_bad_servo
        $error("actuator_drive: servo width range does not fit the frame");
    end
    if ((MOTOR_PERIOD < 2) || (MOTOR_DUTY < 0) || (MOTOR_DUTY > MOTOR_PERIOD)) begin : g_bad_motor
        $error("actuator_drive: motor duty out of range");
    end
    if (DEAD_CYCLES < 1) begin : g_bad_dead
        $error("actuator_drive: DEAD_CYCLES must be at least 1");
    end

    servo_pwm_gen #(
        .SERVO_PERIOD (SERVO_PERIOD),
        .SERVO_CENTER (SERVO_CENTER),
        .SERVO_STEP   (SERVO_STEP)
    ) u_servo (
        .clk         (clk),
        .rst         (rst),
        .front_wheel (front_wheel),
        .servo_pwm   (servo_pwm)
    );

    logic [1:0]     cmd_p0;
    motor_state_t   cmd_state;
    motor_state_t   state;
    motor_state_t   state_nxt;
    logic [DTW-1:0] dead_tmr;
    logic [DTW-1:0] dead_tmr_nxt;
    logic [MCW-1:0] mcnt;
    logic           mcnt_wrap;
    logic [DW-1:0]  duty;
    logic           pwm;
    logic           a_nxt;
    logic           b_nxt;

    assign cmd_state = cmd_to_state(cmd_p0);
    assign mcnt_wrap = (mcnt == MCW'(MOTOR_PERIOD - 1));
    assign pwm       = ({1'b0, mcnt} < duty);

`ifdef ACTUATOR_SOFT_START_EN
    logic [DW-1:0] duty_q;

    // Held at zero outside FWD/REV, so every entry into a drive state starts the ramp from 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_q <= '0;
        end else if ((state != ST_FWD) && (state != ST_REV)) begin
            duty_q <= '0;
        end else if (mcnt_wrap && (duty_q < DW'(MOTOR_DUTY))) begin
            duty_q <= duty_q + 1'b1;
        end
    end

    assign duty = duty_q;
`else
    assign duty = DW'(MOTOR_DUTY);
`endif

    always_comb begin
        state_nxt    = state;
        dead_tmr_nxt = dead_tmr;
        case (state)
            ST_COAST: begin
                state_nxt = cmd_state;
            end
            ST_DEAD: begin
                if (cmd_state == ST_COAST) begin
                    state_nxt = ST_COAST;
                end else if (dead_tmr == '0) begin
                    state_nxt = cmd_state;
                end else begin
                    dead_tmr_nxt = dead_tmr - 1'b1;
                end
            end
            default: begin
                if (cmd_state == ST_COAST) begin
                    state_nxt = ST_COAST;
                end else if (cmd_state != state) begin
                    state_nxt    = ST_DEAD;
                    dead_tmr_nxt = DEAD_LOAD;
                end
            end
        endcase
    end

    always_comb begin
        a_nxt = 1'b0;
        b_nxt = 1'b0;
        case (state)
            ST_FWD:   a_nxt = pwm;
            ST_REV:   b_nxt = pwm;
            ST_BRAKE: begin
                a_nxt = 1'b1;
                b_nxt = 1'b1;
            end
            default: begin
                a_nxt = 1'b0;
                b_nxt = 1'b0;
            end
        endcase
    end

    // Stage p0: command capture; stage p1: state; stage p2: registered pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_p0    <= CMD_COAST;
            state     <= ST_COAST;
            dead_tmr  <= '0;
            mcnt      <= '0;
            motor_a   <= 1'b0;
            motor_b   <= 1'b0;
            reversing <= 1'b0;
        end else begin
            cmd_p0    <= motor;
            state     <= state_nxt;
            dead_tmr  <= dead_tmr_nxt;
            mcnt      <= mcnt_wrap ? '0 : mcnt + 1'b1;
            motor_a   <= a_nxt;
            motor_b   <= b_nxt;
            reversing <= (state == ST_DEAD);
        end
    end

endmodule

// File: tb/tb_actuator_drive.sv
// Directed self-checking bench for actuator_drive with small periods
// (servo frame 100, motor period 10, duty 6, dead time 4).
module tb_actuator_drive;

    logic       clk;
    logic       rst;
    logic [2:0] front_wheel;
    logic [1:0] motor;
    logic       servo_pwm;
    logic       motor_a;
    logic       motor_b;
    logic       reversing;

    int total = 0;
    int bad   = 0;
    int tcnt;

    actuator_drive #(
        .SERVO_PERIOD (100),
        .SERVO_CENTER (15),
        .SERVO_STEP   (2),
        .MOTOR_PERIOD (10),
        .MOTOR_DUTY   (6),
        .DEAD_CYCLES  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .front_wheel (front_wheel),
        .motor       (motor),
        .servo_pwm   (servo_pwm),
        .motor_a     (motor_a),
        .motor_b     (motor_b),
        .reversing   (reversing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges seen since reset release; at a negedge tcnt equals both DUT counters.
    always @(posedge clk or negedge rst) begin
        if (!rst) tcnt <= 0;
        else      tcnt <= tcnt + 1;
    end

    task automatic wait_phase(input int m, input int v);
        int n;
        n = 0;
        while ((tcnt % m) != v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if ((tcnt % m) != v) begin
            total++; bad++;
            $display("FAIL wait_phase: tcnt=%0d never reached %0d mod %0d", tcnt, v, m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        front_wheel = 3'd0;
        motor = 2'b00;
        repeat (3) @(negedge clk);
        total++; if (servo_pwm !== 1'b0) begin bad++; $display("FAIL reset_servo: got %b want 0", servo_pwm); end
        total++; if (motor_a !== 1'b0) begin bad++; $display("FAIL reset_a: got %b want 0", motor_a); end
        total++; if (motor_b !== 1'b0) begin bad++; $display("FAIL reset_b: got %b want 0", motor_b); end
        total++; if (reversing !== 1'b0) begin bad++; $display("FAIL reset_rev: got %b want 0", reversing); end
        rst = 1'b1;
    endtask

    task automatic test_steer_sweep();
        logic [2:0] codes [4];
        int widths [4];
        codes  = '{3'd0, 3'd3, 3'd6, 3'd7};
        widths = '{9, 15, 21, 15};
        for (int k = 0; k < 4; k++) begin
            int highs;
            int errs;
            highs = 0;
            errs  = 0;
            wait_phase(100, 0);
            front_wheel = codes[k];
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (servo_pwm) highs++;
                if (servo_pwm !== (i < widths[k])) errs++;
            end
            total++; if (highs != widths[k]) begin bad++; $display("FAIL sweep_width code=%0d: got %0d want %0d", codes[k], highs, widths[k]); end
            total++; if (errs != 0) begin bad++; $display("FAIL sweep_shape code=%0d: %0d misplaced samples want 0", codes[k], errs); end
        end
    endtask

    task automatic test_steer_mid_pulse();
        int widths [2];
        widths = '{15, 21};
        wait_phase(100, 0);
        front_wheel = 3'd3;
        for (int f = 0; f < 2; f++) begin
            int highs;
            int errs;
            highs = 0;
            errs  = 0;
            for (int i = 0; i < 100; i++) begin
                if (f == 0 && i == 5) front_wheel = 3'd6;
                @(posedge clk);
                @(negedge clk);
                if (servo_pwm) highs++;
                if (servo_pwm !== (i < widths[f])) errs++;
            end
            total++; if (highs != widths[f]) begin bad++; $display("FAIL mid_width frame=%0d: got %0d want %0d", f, highs, widths[f]); end
            total++; if (errs != 0) begin bad++; $display("FAIL mid_shape frame=%0d: %0d misplaced samples want 0", f, errs); end
        end
        front_wheel = 3'd3;
    endtask

    task automatic test_forward();
        int highs;
        highs = 0;
        wait_phase(10, 0);
        motor = 2'b01;
        for (int i = 1; i <= 30; i++) begin
            logic ea;
            @(posedge clk);
            @(negedge clk);
            ea = (i >= 3) && (((i - 1) % 10) < 6);
            if (i > 10 && i <= 20 && motor_a) highs++;
            total++; if (motor_a !== ea) begin bad++; $display("FAIL fwd_a i=%0d: got %b want %b", i, motor_a, ea); end
            total++; if (motor_b !== 1'b0) begin bad++; $display("FAIL fwd_b i=%0d: got %b want 0", i, motor_b); end
        end
        total++; if (highs != 6) begin bad++; $display("FAIL fwd_duty: got %0d want 6", highs); end
    endtask

    task automatic test_reversal();
        int dead;
        logic pa, pb;
        dead = 0;
        wait_phase(10, 0);
        pa = motor_a;
        pb = motor_b;
        motor = 2'b10;
        for (int i = 1; i <= 20; i++) begin
            logic ea, eb, er;
            @(posedge clk);
            @(negedge clk);
            ea = (i <= 2) && (((i - 1) % 10) < 6);
            eb = (i >= 7) && (((i - 1) % 10) < 6);
            er = (i >= 3) && (i <= 6);
            if (reversing) dead++;
            total++; if (motor_a !== ea) begin bad++; $display("FAIL rev_a i=%0d: got %b want %b", i, motor_a, ea); end
            total++; if (motor_b !== eb) begin bad++; $display("FAIL rev_b i=%0d: got %b want %b", i, motor_b, eb); end
            total++; if (reversing !== er) begin bad++; $display("FAIL rev_flag i=%0d: got %b want %b", i, reversing, er); end
            total++;
            if ((pa && !pb && !motor_a && motor_b) || (!pa && pb && motor_a && !motor_b)) begin
                bad++; $display("FAIL rev_shoot i=%0d: got %b%b after %b%b want no direct flip", i, motor_a, motor_b, pa, pb);
            end
            pa = motor_a;
            pb = motor_b;
        end
        total++; if (dead != 4) begin bad++; $display("FAIL rev_dead_len: got %0d want 4", dead); end
    endtask

    task automatic test_brake_mid_dead();
        wait_phase(10, 0);
        motor = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            logic ea, eb, er;
            if (i == 4) motor = 2'b11;
            @(posedge clk);
            @(negedge clk);
            ea = (i >= 7);
            eb = (i >= 7) || ((i <= 2) && (((i - 1) % 10) < 6));
            er = (i >= 3) && (i <= 6);
            total++; if (motor_a !== ea) begin bad++; $display("FAIL brk_a i=%0d: got %b want %b", i, motor_a, ea); end
            total++; if (motor_b !== eb) begin bad++; $display("FAIL brk_b i=%0d: got %b want %b", i, motor_b, eb); end
            total++; if (reversing !== er) begin bad++; $display("FAIL brk_flag i=%0d: got %b want %b", i, reversing, er); end
        end
    endtask

    task automatic test_reset_mid_dead();
        wait_phase(10, 0);
        motor = 2'b01;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        total++; if (reversing !== 1'b1) begin bad++; $display("FAIL rmd_pre_rev: got %b want 1", reversing); end
        rst = 1'b0;
        #1;
        total++; if (motor_a !== 1'b0) begin bad++; $display("FAIL rmd_a: got %b want 0", motor_a); end
        total++; if (motor_b !== 1'b0) begin bad++; $display("FAIL rmd_b: got %b want 0", motor_b); end
        total++; if (reversing !== 1'b0) begin bad++; $display("FAIL rmd_rev: got %b want 0", reversing); end
        total++; if (servo_pwm !== 1'b0) begin bad++; $display("FAIL rmd_servo: got %b want 0", servo_pwm); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            logic ea;
            @(posedge clk);
            @(negedge clk);
            ea = (i >= 3) && (((i - 1) % 10) < 6);
            total++; if (motor_a !== ea) begin bad++; $display("FAIL rmd_post_a i=%0d: got %b want %b", i, motor_a, ea); end
            total++; if (reversing !== 1'b0) begin bad++; $display("FAIL rmd_post_rev i=%0d: got %b want 0", i, reversing); end
        end
    endtask

`ifdef ACTUATOR_SOFT_START_EN
    task automatic test_soft_start();
        wait_phase(10, 0);
        motor = 2'b00;
        repeat (10) @(negedge clk);
        wait_phase(10, 0);
        motor = 2'b01;
        for (int k = 0; k < 9; k++) begin
            int highs;
            int want;
            highs = 0;
            want  = (k < 6) ? k : 6;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (motor_a) highs++;
            end
            total++; if (highs != want) begin bad++; $display("FAIL soft_period=%0d: got %0d want %0d", k, highs, want); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_steer_sweep();
        test_steer_mid_pulse();
        test_forward();
        test_reversal();
        test_brake_mid_dead();
        test_reset_mid_dead();
`ifdef ACTUATOR_SOFT_START_EN
        test_soft_start();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
